// File: rtl/timer_enable_filter_pkg.sv
// timer_enable_filter_pkg: shared FSM encoding and default widths for the enable filter.
package timer_enable_filter_pkg;
    localparam int DEF_FILTER_BITS = 8;
    localparam int DEF_COUNT_BITS  = 16;
    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } state_e;
endpackage

// File: rtl/input_synchronizer.sv
// input_synchronizer: two-flop synchronizer for asynchronous pin levels.
module input_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic sync0_q, sync1_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= d_i;
            sync1_q <= sync0_q;
        end
    end
    assign q_o = sync1_q;
endmodule

// File: rtl/timer_enable_filter.sv
// timer_enable_filter: synchronizes, optionally inverts and glitch-filters the timer enable pin,
// with edge strobes and saturating rise/fall/glitch counts.
module timer_enable_filter
    import timer_enable_filter_pkg::*;
#(
    parameter int FILTER_BITS = DEF_FILTER_BITS,
    parameter int COUNT_BITS  = DEF_COUNT_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pin_in,
    input  logic                   invert,
    input  logic [FILTER_BITS-1:0] filter_len,
    input  logic                   clear,
    output logic                   enable_out,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic [COUNT_BITS-1:0]  rise_count,
    output logic [COUNT_BITS-1:0]  fall_count,
    output logic [COUNT_BITS-1:0]  glitch_count
);
    logic                   sync_lvl;
    logic                   s;
    state_e                 state_q, state_d;
    logic [FILTER_BITS-1:0] cnt_q, cnt_d;
    logic                   glitch;
    logic                   en_q, en_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [COUNT_BITS-1:0]  rise_cnt_q, fall_cnt_q, glitch_cnt_q;

    input_synchronizer u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pin_in),
        .q_o (sync_lvl)
    );

    assign s = sync_lvl ^ invert;

    // Qualification compares against the live filter_len, so lowering it mid-check completes promptly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        glitch  = 1'b0;
        case (state_q)
            ST_LOW: if (s) begin
                state_d = (filter_len == '0) ? ST_HIGH : ST_RISE_CHK;
                cnt_d   = FILTER_BITS'(1);
            end
            ST_RISE_CHK: if (!s) begin
                state_d = ST_LOW;
                glitch  = 1'b1;
            end else if (cnt_q >= filter_len) begin
                state_d = ST_HIGH;
            end else begin
                cnt_d = cnt_q + FILTER_BITS'(1);
            end
            ST_HIGH: if (!s) begin
                state_d = (filter_len == '0) ? ST_LOW : ST_FALL_CHK;
                cnt_d   = FILTER_BITS'(1);
            end
            ST_FALL_CHK: if (s) begin
                state_d = ST_HIGH;
                glitch  = 1'b1;
            end else if (cnt_q >= filter_len) begin
                state_d = ST_LOW;
            end else begin
                cnt_d = cnt_q + FILTER_BITS'(1);
            end
            default: state_d = ST_LOW;
        endcase
    end

    assign en_d   = (state_d == ST_HIGH) || (state_d == ST_FALL_CHK);
    assign rise_d = en_d & ~en_q;
    assign fall_d = ~en_d & en_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_LOW;
            cnt_q        <= '0;
            en_q         <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            rise_cnt_q   <= '0;
            fall_cnt_q   <= '0;
            glitch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            rise_cnt_q   <= clear ? '0 : (rise_d && !(&rise_cnt_q)) ? rise_cnt_q + COUNT_BITS'(1) : rise_cnt_q;
            fall_cnt_q   <= clear ? '0 : (fall_d && !(&fall_cnt_q)) ? fall_cnt_q + COUNT_BITS'(1) : fall_cnt_q;
            glitch_cnt_q <= clear ? '0 : (glitch && !(&glitch_cnt_q)) ? glitch_cnt_q + COUNT_BITS'(1) : glitch_cnt_q;
        end
    end

    assign enable_out   = en_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign rise_count   = rise_cnt_q;
    assign fall_count   = fall_cnt_q;
    assign glitch_count = glitch_cnt_q;
endmodule
